ped_crossing_ctrl: RTL and testbench
====================================

Name: ped_crossing_ctrl

Overview:
- Pedestrian-crossing controller directly downstream of the vehicle light FSM.
- Consumes the one-hot red/yellow/green vehicle lamp signals and a raw push-button.
- Drives WALK and DONT_WALK lamps, granting a walk phase only inside a vehicle red phase.
- Flags a sticky fault if the vehicle lamps are ever not one-hot.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=2)
WALK_TIME, 3, cycles of solid WALK
CLEAR_TIME, 2, cycles of flashing DONT_WALK after WALK
CNT_W, 4, width of phase timer and countdown output; must hold max(WALK_TIME, CLEAR_TIME)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ped_btn  in  1  raw asynchronous pedestrian button, active-high
veh_red  in  1  vehicle red lamp from light FSM
veh_yellow  in  1  vehicle yellow lamp
veh_green  in  1  vehicle green lamp
walk  out  1  WALK lamp
dont_walk  out  1  DONT_WALK lamp (solid or flashing)
countdown  out  CNT_W  remaining clear cycles shown to pedestrians, 0 outside CLEAR
req_pending  out  1  request latched, awaiting service
fault  out  1  sticky lamp-conflict flag

Behaviour:
- All outputs registered.
- Reset values: walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, state=IDLE.
- Internal reset values: red_q=1 (suppresses a false red edge out of reset), debounced level=0, sync flops=0.
- Button path: 2-flop synchronizer, then a stability counter; debounced level flips after DEBOUNCE_CYCLES consecutive samples differing from it; press_evt = debounced rising edge.
- Button latency: if ped_btn is first sampled 1 at edge N and held, req_pending=1 after edge N+DEBOUNCE_CYCLES+2. Default is N+6.
- Glitch rule: pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored and the counter clears.
- red_rise = veh_red & ~red_q.
- lamp_ok = exactly one of veh_red, veh_yellow, veh_green is high, evaluated every cycle.
- States: IDLE, WAIT_RED, WALK, CLEAR, FAULT.
- IDLE: dont_walk=1. On press_evt -> WAIT_RED, req_pending=1.
- WAIT_RED: dont_walk=1. On red_rise -> WALK, timer=WALK_TIME-1, req_pending=0. A request latched while veh_red is already high waits for the next red_rise, because a mid-red grant would leave too little time.
- WALK: walk=1, dont_walk=0, lasting exactly WALK_TIME cycles. When timer==0 -> CLEAR, timer=CLEAR_TIME-1. press_evt in WALK is ignored (already being served).
- CLEAR: walk=0; dont_walk toggles every cycle starting at 1; countdown = timer+1 (CLEAR_TIME down to 1).
  - When timer==0 -> WAIT_RED if a press_evt occurred during CLEAR, else IDLE.
  - countdown returns to 0 on exit.
- Abort: veh_red==0 while in WALK or CLEAR -> IDLE next edge with dont_walk=1, walk=0. Any pending request is kept and the state goes to WAIT_RED instead.
- Fault: lamp_ok==0 in any state -> FAULT next edge. Outputs in FAULT: walk=0, dont_walk=1 solid, countdown=0, fault=1, req_pending=0. FAULT is held until rst.
- Priority on the same edge: rst > fault detect > abort > timer expiry > press_evt.
- Timer: unsigned CNT_W bits, decrements by 1, never wraps (its value is only used in WALK/CLEAR).
- Static requirement: WALK_TIME+CLEAR_TIME must not exceed the vehicle red duration (6 cycles for the current light FSM). Defaults use 5.
- Reset mid-operation: outputs return to reset values on the edge after rst is sampled high.

Decomposition:
- traffic_pkg holds:
  - the shared vehicle light state enum (RED, GREEN, YELLOW), also used by the light FSM;
  - the ped_state_t enum (IDLE, WAIT_RED, WALK, CLEAR, FAULT);
  - default timing constants.
- One sub-module: ped_btn_debounce (synchronizer, stability counter, debounced level, press_evt pulse), parameterised by DEBOUNCE_CYCLES.

Test Plan:
- Free-running light FSM (red 6, green 6, yellow 3). ped_btn=1 held from edge 10 during green -> req_pending=1 after edge 16; at the next red_rise walk=1 for 3 cycles; then dont_walk sequence 1,0 with countdown 2,1; then IDLE with dont_walk=1, countdown=0.
- ped_btn high for 2 cycles only -> req_pending stays 0 and walk is never asserted.
- Request latched during the second cycle of red -> no walk this red phase; walk starts on the following red_rise.
- Second press during CLEAR -> after CLEAR ends, state goes to WAIT_RED with req_pending=1, and walk is granted at the next red phase.
- Force veh_red=1 and veh_green=1 together for one cycle mid-WALK -> next edge fault=1, walk=0, dont_walk=1. Holds through later valid lamps until rst; after rst, all outputs are at reset values.
- Force veh_red low on the 2nd WALK cycle -> next edge walk=0, dont_walk=1, state IDLE. Assert rst mid-CLEAR -> countdown=0, dont_walk=1 after the next edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light/pedestrian state types and default timing
package traffic_pkg;
   typedef enum logic [1:0] {RED, GREEN, YELLOW} light_t;
   typedef enum logic [2:0] {IDLE, WAIT_RED, WALK, CLEAR, FAULT} ped_state_t;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_WALK_TIME = 3;
   localparam int DEF_CLEAR_TIME = 2;
   localparam int DEF_CNT_W = 4;
   localparam int RED_CYCLES = 6;
   localparam int GREEN_CYCLES = 6;
   localparam int YELLOW_CYCLES = 3;
   function automatic int light_dur(input light_t l);
      return (l == RED) ? RED_CYCLES : (l == GREEN) ? GREEN_CYCLES : YELLOW_CYCLES;
   endfunction
   function automatic light_t light_next(input light_t l);
      return (l == RED) ? GREEN : (l == GREEN) ? YELLOW : RED;
   endfunction
endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// ped_crossing_ctrl_if: vehicle lamps and button in, pedestrian lamps out
interface ped_crossing_ctrl_if #(parameter int CNT_W = 4);
   logic             ped_btn;
   logic             veh_red;
   logic             veh_yellow;
   logic             veh_green;
   logic             walk;
   logic             dont_walk;
   logic [CNT_W-1:0] countdown;
   logic             req_pending;
   logic             fault;
   modport master (output ped_btn, veh_red, veh_yellow, veh_green,
                   input walk, dont_walk, countdown, req_pending, fault);
   modport slave (input ped_btn, veh_red, veh_yellow, veh_green,
                  output walk, dont_walk, countdown, req_pending, fault);
endinterface

// File: rtl/ped_btn_debounce.sv
// ped_btn_debounce: synchronise raw button, debounce, pulse on accepted press
module ped_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic          s1_q, s2_q, lvl_q, diff, flip;
   logic [CW-1:0] cnt_q, cnt_d;
   assign diff  = s2_q ^ lvl_q;
   assign flip  = diff && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
   assign cnt_d = (diff && !flip) ? cnt_q + 1'b1 : '0;
   // any sample matching the current level clears the run; a full run flips it
   always_ff @(posedge clk)
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
         press_o <= 1'b0;
      end else begin
         s1_q    <= btn_i;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         lvl_q   <= flip ? s2_q : lvl_q;
         press_o <= flip & s2_q;
      end
endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: grants a walk phase at the start of each vehicle red
module ped_crossing_ctrl
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int WALK_TIME       = DEF_WALK_TIME,
   parameter int CLEAR_TIME      = DEF_CLEAR_TIME,
   parameter int CNT_W           = DEF_CNT_W
) (
   input logic clk,
   input logic rst,
   ped_crossing_ctrl_if.slave bus
);
   ped_state_t       state_q;
   logic [CNT_W-1:0] timer_q, cd_q;
   logic             red_q, walk_q, dw_q, req_q, fault_q;
   logic             press, lamp_ok, red_rise;

   ped_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.ped_btn),
      .press_o (press)
   );

   assign lamp_ok  = (bus.veh_red ^ bus.veh_yellow ^ bus.veh_green) &
                     ~(bus.veh_red & bus.veh_yellow & bus.veh_green);
   assign red_rise = bus.veh_red & ~red_q;

   assign bus.walk        = walk_q;
   assign bus.dont_walk   = dw_q;
   assign bus.countdown   = cd_q;
   assign bus.req_pending = req_q;
   assign bus.fault       = fault_q;

   // crossing FSM: fault beats abort beats timer expiry beats a new press
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         red_q   <= 1'b1;
         walk_q  <= 1'b0;
         dw_q    <= 1'b1;
         cd_q    <= '0;
         req_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         red_q <= bus.veh_red;
         if (!lamp_ok || state_q == FAULT) begin
            state_q <= FAULT;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            cd_q    <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE:
                  if (press) begin
                     state_q <= WAIT_RED;
                     req_q   <= 1'b1;
                  end
               WAIT_RED:
                  if (red_rise) begin
                     state_q <= WALK;
                     timer_q <= CNT_W'(WALK_TIME - 1);
                     req_q   <= 1'b0;
                     walk_q  <= 1'b1;
                     dw_q    <= 1'b0;
                  end
               WALK:
                  if (!bus.veh_red) begin
                     state_q <= req_q ? WAIT_RED : IDLE;
                     walk_q  <= 1'b0;
                     dw_q    <= 1'b1;
                  end else if (timer_q == '0) begin
                     state_q <= CLEAR;
                     timer_q <= CNT_W'(CLEAR_TIME - 1);
                     walk_q  <= 1'b0;
                     dw_q    <= 1'b1;
                     cd_q    <= CNT_W'(CLEAR_TIME);
                  end else begin
                     timer_q <= timer_q - 1'b1;
                  end
               CLEAR:
                  if (!bus.veh_red || timer_q == '0) begin
                     state_q <= req_q ? WAIT_RED : IDLE;
                     dw_q    <= 1'b1;
                     cd_q    <= '0;
                  end else begin
                     timer_q <= timer_q - 1'b1;
                     dw_q    <= ~dw_q;
                     cd_q    <= timer_q;
                     req_q   <= req_q | press;
                  end
               default: state_q <= FAULT;
            endcase
         end
      end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed checks against a free-running light sequence
module tb_ped_crossing_ctrl
   import traffic_pkg::*;
;
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   lrst = 1'b1;
   logic   ov_en = 1'b0;
   logic [2:0] ov = 3'b000;
   light_t lst;
   int     lc;
   int     ecnt = 0;
   int     checks = 0;
   int     failures = 0;

   ped_crossing_ctrl_if #(.CNT_W(4)) bus();

   ped_crossing_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // light FSM model: red 6, green 6, yellow 3
   always @(posedge clk)
      if (lrst) begin
         lst <= RED;
         lc  <= 0;
      end else if (lc == light_dur(lst) - 1) begin
         lst <= light_next(lst);
         lc  <= 0;
      end else begin
         lc <= lc + 1;
      end

   // edge numbering: E1 is the first edge after the light model is released
   always @(posedge clk) ecnt <= lrst ? 0 : ecnt + 1;

   // lamps come from the light model unless a step overrides them
   always_comb begin
      {bus.veh_red, bus.veh_yellow, bus.veh_green} = ov_en ? ov :
         {lst == RED, lst == YELLOW, lst == GREEN};
   end

   task automatic at(input int k);
      while (ecnt < k) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input int w, input int dw, input int cd,
                       input int rq, input int f);
      chk({tag, ".walk"}, 32'(bus.walk), w);
      chk({tag, ".dont_walk"}, 32'(bus.dont_walk), dw);
      chk({tag, ".countdown"}, 32'(bus.countdown), cd);
      chk({tag, ".req_pending"}, 32'(bus.req_pending), rq);
      chk({tag, ".fault"}, 32'(bus.fault), f);
   endtask

   initial begin
      bus.ped_btn = 1'b0;
      repeat (3) @(negedge clk);
      outs("reset", 0, 1, 0, 0, 0);
      rst  = 1'b0;
      lrst = 1'b0;
      // held press during green, served at the red after next
      at(9);  bus.ped_btn = 1'b1;
      at(15); chk("t1.req_e15", 32'(bus.req_pending), 0);
      at(16); chk("t1.req_e16", 32'(bus.req_pending), 1);
      at(18); bus.ped_btn = 1'b0;
      at(30); outs("t1.e30", 0, 1, 0, 1, 0);
      at(31); outs("t1.walk1", 1, 0, 0, 0, 0);
      at(32); outs("t1.walk2", 1, 0, 0, 0, 0);
      at(33); outs("t1.walk3", 1, 0, 0, 0, 0);
      at(34); outs("t1.clr1", 0, 1, 2, 0, 0);
      at(35); outs("t1.clr2", 0, 0, 1, 0, 0);
      at(36); outs("t1.idle", 0, 1, 0, 0, 0);
      at(37); outs("t1.idle2", 0, 1, 0, 0, 0);
      // two-cycle glitch is ignored, including through the next red
      at(39); bus.ped_btn = 1'b1;
      at(41); bus.ped_btn = 1'b0;
      for (int k = 42; k <= 55; k++) begin
         at(k);
         chk("t2.walk", 32'(bus.walk), 0);
         chk("t2.req", 32'(bus.req_pending), 0);
      end
      // request latched on the second red cycle waits for the next red
      at(55); bus.ped_btn = 1'b1;
      at(61); chk("t3.req_e61", 32'(bus.req_pending), 0);
      at(62); chk("t3.req_e62", 32'(bus.req_pending), 1);
      bus.ped_btn = 1'b0;
      for (int k = 63; k <= 66; k++) begin
         at(k);
         chk("t3.nowalk", 32'(bus.walk), 0);
      end
      at(73); bus.ped_btn = 1'b1;
      at(75); outs("t3.e75", 0, 1, 0, 1, 0);
      at(76); outs("t3.walk", 1, 0, 0, 0, 0);
      // second press during clear re-arms the request
      at(79); outs("t4.clr1", 0, 1, 2, 0, 0);
      at(80); outs("t4.clr2", 0, 0, 1, 1, 0);
      at(81); outs("t4.wait", 0, 1, 0, 1, 0);
      at(83); bus.ped_btn = 1'b0;
      at(90); outs("t4.e90", 0, 1, 0, 1, 0);
      at(91); outs("t4.walk", 1, 0, 0, 0, 0);
      // red drops on the second walk cycle
      ov = 3'b001; ov_en = 1'b1;
      at(92); ov_en = 1'b0;
      outs("t6.abort", 0, 1, 0, 0, 0);
      at(93); outs("t6.idle", 0, 1, 0, 0, 0);
      // reset in the middle of clear
      at(94);  bus.ped_btn = 1'b1;
      at(101); chk("t6.req", 32'(bus.req_pending), 1);
      at(103); bus.ped_btn = 1'b0;
      at(106); outs("t6.walk", 1, 0, 0, 0, 0);
      at(109); outs("t6.clr1", 0, 1, 2, 0, 0);
      rst = 1'b1;
      at(110); outs("t6.rst", 0, 1, 0, 0, 0);
      rst = 1'b0;
      // lamp conflict during walk is sticky until reset
      at(111); bus.ped_btn = 1'b1;
      at(118); chk("t5.req", 32'(bus.req_pending), 1);
      at(121); outs("t5.walk", 1, 0, 0, 0, 0);
      ov = 3'b101; ov_en = 1'b1;
      at(122); ov_en = 1'b0;
      outs("t5.fault", 0, 1, 0, 0, 1);
      at(125); bus.ped_btn = 1'b0;
      at(130); outs("t5.hold1", 0, 1, 0, 0, 1);
      at(136); outs("t5.hold2", 0, 1, 0, 0, 1);
      at(140); rst = 1'b1;
      at(141); outs("t5.rst", 0, 1, 0, 0, 0);
      rst = 1'b0;
      at(146); outs("t5.after", 0, 1, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
